// File: rtl/food_map_pkg.sv
// Shared definitions for the food map write path: map geometry, the
// writer FSM state type and the one-hot direction codes used by game logic.
package food_map_pkg;

    localparam int ROW_W  = 80;   // bits per map row, bit x = column x
    localparam int ROWS   = 64;   // number of map rows
    localparam int ADDR_W = 6;    // row address width
    localparam int COL_W  = 7;    // column index width
    localparam int PC_W   = $clog2(ROW_W + 1);  // width of a row popcount

    typedef enum logic [2:0] {
        REFILL_RD,
        REFILL_WAIT,
        REFILL_WR,
        IDLE,
        EAT_RD,
        EAT_WAIT,
        EAT_WR
    } fm_state_t;

    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_UP    = 4'b0100;
    localparam logic [3:0] DIR_DOWN  = 4'b1000;

endpackage

// File: rtl/food_map_writer_popcount.sv
// Combinational popcount of one map row; used to total pellets during refill.
module row_popcount
    import food_map_pkg::*;
(
    input  logic [ROW_W-1:0] i_row,
    output logic [PC_W-1:0]  o_count
);

    // Sum the set bits of the row
    always_comb begin
        o_count = '0;
        for (int unsigned i = 0; i < ROW_W; i++) begin
            o_count = o_count + PC_W'(i_row[i]);
        end
    end

endmodule

// File: rtl/food_map_writer.sv
// Write-side owner of the food map RAM (port A). Rebuilds the map from the
// init ROM after reset or on request, and clears eaten pellets by
// read-modify-write. Optional request FIFO: define FOOD_EAT_FIFO_EN.
module food_map_writer
    import food_map_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              eat_valid,
    output logic              eat_ready,
    input  logic [COL_W-1:0]  eat_x,
    input  logic [ADDR_W-1:0] eat_y,
    input  logic              refill_req,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [ROW_W-1:0]  ram_din,
    input  logic [ROW_W-1:0]  ram_dout,
    input  logic [ROW_W-1:0]  init_row,
    output logic              pellet_eaten,
    output logic              eat_miss,
    output logic [CNT_W-1:0]  pellets_left,
    output logic              map_cleared,
    output logic              busy
);

    localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W:0]   ROWS_L   = (ADDR_W + 1)'(ROWS);
    localparam logic [COL_W-1:0]  ROW_W_L  = COL_W'(ROW_W);

    fm_state_t          r_state;
    logic [WAIT_W-1:0]  r_wait;
    logic [COL_W-1:0]   r_x;
    logic               r_refill_pend;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic               r_ram_we;
    logic [ROW_W-1:0]   r_ram_din;
    logic               r_eaten;
    logic               r_miss;
    logic [CNT_W-1:0]   r_pellets;
    logic               r_cleared;
    logic               r_busy;

    logic [PC_W-1:0]    w_pop;
    logic               w_req_valid;
    logic [COL_W-1:0]   w_req_x;
    logic [ADDR_W-1:0]  w_req_y;
    logic               w_req_take;
    logic               w_req_oob;

    row_popcount u_pop (
        .i_row   (init_row),
        .o_count (w_pop)
    );

    // A refill request in IDLE always beats a pending eat request.
    assign w_req_take = (r_state == IDLE) && !refill_req && w_req_valid;
    assign w_req_oob  = (w_req_x >= ROW_W_L) || ({1'b0, w_req_y} >= ROWS_L);

`ifdef FOOD_EAT_FIFO_EN
    logic [COL_W+ADDR_W-1:0] r_fifo [4];
    logic [1:0]              r_wr_ptr;
    logic [1:0]              r_rd_ptr;
    logic [2:0]              r_fifo_cnt;
    logic                    w_fifo_full;
    logic                    w_flush;
    logic                    w_push;

    assign w_flush     = (r_state == REFILL_RD) || (r_state == REFILL_WAIT) ||
                         (r_state == REFILL_WR);
    assign w_fifo_full = (r_fifo_cnt == 3'd4);
    assign w_push      = eat_valid && !w_fifo_full && !w_flush;
    assign eat_ready   = !w_fifo_full;
    assign w_req_valid = (r_fifo_cnt != 3'd0);
    assign {w_req_x, w_req_y} = r_fifo[r_rd_ptr];

    // Request FIFO; anything accepted while a refill runs is discarded
    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= {eat_x, eat_y};
                r_wr_ptr         <= r_wr_ptr + 2'd1;
            end
            if (w_req_take) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            r_fifo_cnt <= r_fifo_cnt + {2'b0, w_push} - {2'b0, w_req_take};
        end
    end
`else
    assign w_req_valid = eat_valid;
    assign w_req_x     = eat_x;
    assign w_req_y     = eat_y;
    assign eat_ready   = (r_state == IDLE) && !refill_req;
`endif

    // Main FSM; outputs are registered so each state's outputs appear on entry.
    // WAIT states last RD_LAT cycles and sample read data in their last cycle,
    // so the write (and pulse) lands in the WR state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= REFILL_RD;
            r_wait        <= '0;
            r_x           <= '0;
            r_refill_pend <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_we      <= 1'b0;
            r_ram_din     <= '0;
            r_eaten       <= 1'b0;
            r_miss        <= 1'b0;
            r_pellets     <= '0;
            r_cleared     <= 1'b0;
            r_busy        <= 1'b1;
        end else begin
            r_ram_we <= 1'b0;
            r_eaten  <= 1'b0;
            r_miss   <= 1'b0;
            unique case (r_state)
                REFILL_RD: begin
                    r_state <= REFILL_WAIT;
                    r_wait  <= WAIT_W'(RD_LAT - 1);
                end
                REFILL_WAIT: begin
                    if (r_wait == '0) begin
                        r_state   <= REFILL_WR;
                        r_ram_we  <= 1'b1;
                        r_ram_din <= init_row;
                        r_pellets <= r_pellets + CNT_W'(w_pop);
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end
                REFILL_WR: begin
                    if (r_ram_addr == LAST_ROW) begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_cleared <= (r_pellets == '0);
                    end else begin
                        r_state    <= REFILL_RD;
                        r_ram_addr <= r_ram_addr + ADDR_W'(1);
                    end
                end
                IDLE: begin
                    r_cleared <= (r_pellets == '0);
                    if (refill_req) begin
                        r_state       <= REFILL_RD;
                        r_ram_addr    <= '0;
                        r_pellets     <= '0;
                        r_refill_pend <= 1'b0;
                        r_busy        <= 1'b1;
                        r_cleared     <= 1'b0;
                    end else if (w_req_take) begin
                        if (w_req_oob) begin
                            r_miss <= 1'b1;
                        end else begin
                            r_state    <= EAT_RD;
                            r_x        <= w_req_x;
                            r_ram_addr <= w_req_y;
                            r_busy     <= 1'b1;
                            r_cleared  <= 1'b0;
                        end
                    end
                end
                EAT_RD: begin
                    r_state <= EAT_WAIT;
                    r_wait  <= WAIT_W'(RD_LAT - 1);
                    if (refill_req) begin
                        r_refill_pend <= 1'b1;
                    end
                end
                EAT_WAIT: begin
                    if (refill_req) begin
                        r_refill_pend <= 1'b1;
                    end
                    if (r_wait == '0) begin
                        r_state <= EAT_WR;
                        if (ram_dout[r_x]) begin
                            r_ram_we  <= 1'b1;
                            r_ram_din <= ram_dout & ~(ROW_W'(1) << r_x);
                            r_eaten   <= 1'b1;
                            r_pellets <= (r_pellets == '0) ? '0 : r_pellets - CNT_W'(1);
                        end else begin
                            r_miss <= 1'b1;
                        end
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end
                EAT_WR: begin
                    if (r_refill_pend || refill_req) begin
                        r_state       <= REFILL_RD;
                        r_ram_addr    <= '0;
                        r_pellets     <= '0;
                        r_refill_pend <= 1'b0;
                    end else begin
                        r_state   <= IDLE;
                        r_busy    <= 1'b0;
                        r_cleared <= (r_pellets == '0);
                    end
                end
                default: begin
                    r_state    <= REFILL_RD;
                    r_ram_addr <= '0;
                    r_pellets  <= '0;
                    r_busy     <= 1'b1;
                end
            endcase
        end
    end

    assign ram_addr     = r_ram_addr;
    assign ram_we       = r_ram_we;
    assign ram_din      = r_ram_din;
    assign pellet_eaten = r_eaten;
    assign eat_miss     = r_miss;
    assign pellets_left = r_pellets;
    assign map_cleared  = r_cleared;
    assign busy         = r_busy;

endmodule

// File: tb/tb_food_map_writer.sv
// Bench for food_map_writer: RAM and init-ROM models with one-cycle latency,
// a queue of expected eat pulses checked by an independent monitor.
module tb_food_map_writer;
    import food_map_pkg::*;

    localparam int CNT_W = 13;

    logic              clk = 1'b0;
    logic              rst;
    logic              eat_valid;
    logic              eat_ready;
    logic [COL_W-1:0]  eat_x;
    logic [ADDR_W-1:0] eat_y;
    logic              refill_req;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [ROW_W-1:0]  ram_din;
    logic [ROW_W-1:0]  ram_dout;
    logic [ROW_W-1:0]  init_row;
    logic              pellet_eaten;
    logic              eat_miss;
    logic [CNT_W-1:0]  pellets_left;
    logic              map_cleared;
    logic              busy;

    logic [ROW_W-1:0]  mem [ROWS];
    logic [ROW_W-1:0]  rom [ROWS];

    typedef struct {
        bit          hit;
        int unsigned cyc;
        int unsigned pel;
    } exp_t;
    exp_t q[$];

    int unsigned cyc = 0;
    int unsigned wr_cnt = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    food_map_writer #(.RD_LAT(1), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .eat_valid    (eat_valid),
        .eat_ready    (eat_ready),
        .eat_x        (eat_x),
        .eat_y        (eat_y),
        .refill_req   (refill_req),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_din      (ram_din),
        .ram_dout     (ram_dout),
        .init_row     (init_row),
        .pellet_eaten (pellet_eaten),
        .eat_miss     (eat_miss),
        .pellets_left (pellets_left),
        .map_cleared  (map_cleared),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM port A and init ROM, both one cycle read latency
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
        init_row <= rom[ram_addr];
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every eat pulse must match the head of the expectation queue
    always @(negedge clk) begin
        exp_t e;
        if (ram_we === 1'b1) wr_cnt++;
        if (pellet_eaten === 1'b1 || eat_miss === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", {pellet_eaten, eat_miss}, 2'b00);
            end else begin
                e = q.pop_front();
                check("pulse_hit", pellet_eaten, e.hit);
                check("pulse_miss", eat_miss, !e.hit);
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_pellets", pellets_left, e.pel);
            end
        end
    end

    // Issue one eat request at a negedge; returns at the negedge after the handshake
    task automatic do_eat(input logic [COL_W-1:0] x, input logic [ADDR_W-1:0] y,
                          input bit push, input bit hit, input int unsigned lat,
                          input int unsigned pel);
        int unsigned t = 0;
        eat_x = x;
        eat_y = y;
        eat_valid = 1'b1;
        #1;
        while (eat_ready !== 1'b1 && t < 500) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (eat_ready !== 1'b1) check("eat_ready_timeout", eat_ready, 1'b1);
        if (push) q.push_back('{hit, cyc + lat, pel});
        @(negedge clk);
        eat_valid = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned max_cyc);
        int unsigned t = 0;
        @(negedge clk);
        while ((busy !== 1'b0 || q.size() != 0) && t < max_cyc) begin
            @(negedge clk);
            t++;
        end
        if (busy !== 1'b0 || q.size() != 0) check("idle_timeout", {busy, 32'(q.size())}, 33'd0);
    endtask

    initial begin
        int unsigned k;
        int unsigned t;
        int unsigned w0;
        logic [ADDR_W-1:0] a0;

        for (int i = 0; i < ROWS; i++) rom[i] = ROW_W'(1);
        rst = 1'b1;
        eat_valid = 1'b0;
        eat_x = '0;
        eat_y = '0;
        refill_req = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_ram_addr", ram_addr, 6'd0);
        check("rst_ram_din", ram_din, 80'd0);
        check("rst_pulses", {pellet_eaten, eat_miss}, 2'b00);
        check("rst_pellets", pellets_left, 13'd0);
        check("rst_cleared", map_cleared, 1'b0);
        check("rst_busy", busy, 1'b1);
        check("rst_eat_ready", eat_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        k = cyc;
        w0 = wr_cnt;

        // Automatic refill: 64 rows x 3 cycles
        t = 0;
        while (busy !== 1'b0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("refill_cycles", cyc - k, 192);
        check("refill_writes", wr_cnt - w0, 64);
        check("refill_pellets", pellets_left, 13'd64);
        check("refill_cleared", map_cleared, 1'b0);
        check("idle_eat_ready", eat_ready, 1'b1);

        // Eat hit at (0,5)
        w0 = wr_cnt;
        do_eat(7'd0, 6'd5, 1'b1, 1'b1, 3, 63);
        wait_idle(100);
        check("hit_row5", mem[5], 80'd0);
        check("hit_pellets", pellets_left, 13'd63);
        check("hit_writes", wr_cnt - w0, 1);

        // Same block again: miss, no write
        w0 = wr_cnt;
        do_eat(7'd0, 6'd5, 1'b1, 1'b0, 3, 63);
        wait_idle(100);
        check("miss_writes", wr_cnt - w0, 0);
        check("miss_pellets", pellets_left, 13'd63);

        // Out of range columns: immediate miss, no RAM activity
        w0 = wr_cnt;
        a0 = ram_addr;
        do_eat(7'd80, 6'd0, 1'b1, 1'b0, 1, 63);
        wait_idle(100);
        do_eat(7'd127, 6'd9, 1'b1, 1'b0, 1, 63);
        wait_idle(100);
        check("oob_addr", ram_addr, a0);
        check("oob_writes", wr_cnt - w0, 0);

        // Last in-range column, clear bit: in-range miss
        do_eat(7'd79, 6'd0, 1'b1, 1'b0, 3, 63);
        wait_idle(100);

        // Refill request during EAT_WAIT: eat write first, then refill
        w0 = wr_cnt;
        do_eat(7'd0, 6'd6, 1'b1, 1'b1, 3, 62);
        @(negedge clk);
        refill_req = 1'b1;
        @(negedge clk);
        refill_req = 1'b0;
        wait_idle(1000);
        check("coll_writes", wr_cnt - w0, 65);
        check("coll_row5", mem[5], 80'd1);
        check("coll_row6", mem[6], 80'd1);
        check("coll_pellets", pellets_left, 13'd64);

        // Refill beats a simultaneous eat; a mid-refill request is ignored
        eat_x = 7'd0;
        eat_y = 6'd7;
        eat_valid = 1'b1;
        refill_req = 1'b1;
        #1;
        check("refill_wins_ready", eat_ready, 1'b0);
        k = cyc;
        @(negedge clk);
        eat_valid = 1'b0;
        refill_req = 1'b0;
        t = 0;
        while (busy !== 1'b0 && t < 1000) begin
            refill_req = (cyc == k + 50);
            @(negedge clk);
            t++;
        end
        refill_req = 1'b0;
        check("req_refill_cycles", cyc - k, 193);
        check("req_refill_row7", mem[7], 80'd1);
        check("req_refill_pellets", pellets_left, 13'd64);

        // Eat every pellet
        for (int y = 0; y < ROWS; y++) begin
            do_eat(7'd0, ADDR_W'(y), 1'b1, 1'b1, 3, 63 - y);
            wait_idle(100);
        end
        @(negedge clk);
        check("all_eaten_pellets", pellets_left, 13'd0);
        check("map_cleared", map_cleared, 1'b1);

        // Empty map: miss, count stays at zero
        do_eat(7'd0, 6'd0, 1'b1, 1'b0, 3, 0);
        wait_idle(100);
        check("sat_pellets", pellets_left, 13'd0);
        check("sat_cleared", map_cleared, 1'b1);

        // Refill, then reset in the middle of a read-modify-write
        refill_req = 1'b1;
        @(negedge clk);
        refill_req = 1'b0;
        wait_idle(1000);
        check("refill2_pellets", pellets_left, 13'd64);
        do_eat(7'd0, 6'd3, 1'b0, 1'b0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_we", ram_we, 1'b0);
        check("rst_mid_pulse", pellet_eaten, 1'b0);
        check("rst_mid_busy", busy, 1'b1);
        check("rst_mid_addr", ram_addr, 6'd0);
        rst = 1'b0;
        wait_idle(1000);
        check("rst_mid_pellets", pellets_left, 13'd64);
        check("rst_mid_row3", mem[3], 80'd1);
        check("queue_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
